// File: rtl/id_ex_if.sv
// ID-to-EX pipeline bundle: decoded fields from ID (driven by the master) and
// the registered EX-side copies (driven by the ID/EX stage as slave).
interface id_ex_if #(
    parameter int DATA_W = 32
);
    logic              valid_id;
    logic [4:0]        rs_id;
    logic [4:0]        rt_id;
    logic [4:0]        rd_id;
    logic              uses_rt_id;
    logic [DATA_W-1:0] rdata1_id;
    logic [DATA_W-1:0] rdata2_id;
    logic [DATA_W-1:0] imm_id;
    logic              reg_write_id;
    logic              mem_read_id;
    logic              mem_write_id;
    logic              mem_to_reg_id;
    logic              alu_src_id;
    logic              reg_dst_id;
    logic [2:0]        alu_op_id;

    logic              valid_ex;
    logic [4:0]        rs_ex;
    logic [4:0]        rt_ex;
    logic [4:0]        dest_ex;
    logic [DATA_W-1:0] rdata1_ex;
    logic [DATA_W-1:0] rdata2_ex;
    logic [DATA_W-1:0] imm_ex;
    logic              reg_write_ex;
    logic              mem_read_ex;
    logic              mem_write_ex;
    logic              mem_to_reg_ex;
    logic              alu_src_ex;
    logic [2:0]        alu_op_ex;

    modport master (
        output valid_id, rs_id, rt_id, rd_id, uses_rt_id,
               rdata1_id, rdata2_id, imm_id,
               reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id,
               alu_src_id, reg_dst_id, alu_op_id,
        input  valid_ex, rs_ex, rt_ex, dest_ex, rdata1_ex, rdata2_ex, imm_ex,
               reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex,
               alu_src_ex, alu_op_ex
    );

    modport slave (
        input  valid_id, rs_id, rt_id, rd_id, uses_rt_id,
               rdata1_id, rdata2_id, imm_id,
               reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id,
               alu_src_id, reg_dst_id, alu_op_id,
        output valid_ex, rs_ex, rt_ex, dest_ex, rdata1_ex, rdata2_ex, imm_ex,
               reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex,
               alu_src_ex, alu_op_ex
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle stall
// generation and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_if.slave           bus,
    input  logic             flush,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] stall_count
);
    logic       hazard;
    logic       bubble;
    logic [4:0] dest_next;

    // A load in EX whose target is read by the ID instruction must be held one cycle.
    assign hazard = bus.valid_id & bus.valid_ex & bus.mem_read_ex & (bus.rt_ex != 5'd0) &
                    ((bus.rt_ex == bus.rs_id) | (bus.uses_rt_id & (bus.rt_ex == bus.rt_id)));
    assign stall       = hazard & ~flush;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign bubble      = flush | stall | ~bus.valid_id;
    assign dest_next   = bus.reg_dst_id ? bus.rd_id : bus.rt_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_ex      <= 1'b0;
            bus.rs_ex         <= 5'd0;
            bus.rt_ex         <= 5'd0;
            bus.dest_ex       <= 5'd0;
            bus.rdata1_ex     <= '0;
            bus.rdata2_ex     <= '0;
            bus.imm_ex        <= '0;
            bus.reg_write_ex  <= 1'b0;
            bus.mem_read_ex   <= 1'b0;
            bus.mem_write_ex  <= 1'b0;
            bus.mem_to_reg_ex <= 1'b0;
            bus.alu_src_ex    <= 1'b0;
            bus.alu_op_ex     <= 3'd0;
        end else if (bubble) begin
            // Zeroed specifiers keep a bubble from matching any forwarding/hazard compare.
            bus.valid_ex      <= 1'b0;
            bus.rs_ex         <= 5'd0;
            bus.rt_ex         <= 5'd0;
            bus.dest_ex       <= 5'd0;
            bus.rdata1_ex     <= '0;
            bus.rdata2_ex     <= '0;
            bus.imm_ex        <= '0;
            bus.reg_write_ex  <= 1'b0;
            bus.mem_read_ex   <= 1'b0;
            bus.mem_write_ex  <= 1'b0;
            bus.mem_to_reg_ex <= 1'b0;
            bus.alu_src_ex    <= 1'b0;
            bus.alu_op_ex     <= 3'd0;
        end else begin
            bus.valid_ex      <= 1'b1;
            bus.rs_ex         <= bus.rs_id;
            bus.rt_ex         <= bus.rt_id;
            bus.dest_ex       <= dest_next;
            bus.rdata1_ex     <= bus.rdata1_id;
            bus.rdata2_ex     <= bus.rdata2_id;
            bus.imm_ex        <= bus.imm_id;
            // Writes to $0 die here so forwarding never needs a zero check.
            bus.reg_write_ex  <= bus.reg_write_id & (dest_next != 5'd0);
            bus.mem_read_ex   <= bus.mem_read_id;
            bus.mem_write_ex  <= bus.mem_write_id;
            bus.mem_to_reg_ex <= bus.mem_to_reg_id;
            bus.alu_src_ex    <= bus.alu_src_id;
            bus.alu_op_ex     <= bus.alu_op_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stalls, flush priority,
// $0 suppression, counter saturation (CNT_W=2) and asynchronous reset.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    localparam logic [5:0] C_RTYPE = 6'b100001;
    localparam logic [5:0] C_LW    = 6'b110110;
    localparam logic [5:0] C_ADDI  = 6'b100010;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             stall;
    logic             pc_write;
    logic             if_id_write;
    logic [CNT_W-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    id_ex_if #(.DATA_W(DATA_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .flush       (flush),
        .stall       (stall),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic urt, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] imm,
                      input logic [5:0] ctl, input logic [2:0] op);
        bus.valid_id      = v;
        bus.rs_id         = rs;
        bus.rt_id         = rt;
        bus.rd_id         = rd;
        bus.uses_rt_id    = urt;
        bus.rdata1_id     = r1;
        bus.rdata2_id     = r2;
        bus.imm_id        = imm;
        bus.reg_write_id  = ctl[5];
        bus.mem_read_id   = ctl[4];
        bus.mem_write_id  = ctl[3];
        bus.mem_to_reg_id = ctl[2];
        bus.alu_src_id    = ctl[1];
        bus.reg_dst_id    = ctl[0];
        bus.alu_op_id     = op;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 3'd0);
        #12;
        chk("rst_valid_ex", 32'(bus.valid_ex), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3,$1,$2
        id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, 32'h0, C_RTYPE, 3'd2);
        chk("pt_stall", 32'(stall), 32'd0);
        tick();
        chk("pt_rs_ex", 32'(bus.rs_ex), 32'd1);
        chk("pt_rt_ex", 32'(bus.rt_ex), 32'd2);
        chk("pt_dest_ex", 32'(bus.dest_ex), 32'd3);
        chk("pt_reg_write_ex", 32'(bus.reg_write_ex), 32'd1);
        chk("pt_rdata1_ex", bus.rdata1_ex, 32'h11);
        chk("pt_rdata2_ex", bus.rdata2_ex, 32'h22);
        chk("pt_alu_op_ex", 32'(bus.alu_op_ex), 32'd2);
        chk("pt_valid_ex", 32'(bus.valid_ex), 32'd1);

        // lw $5,4($1) then add $6,$5,$2
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        chk("lw_no_stall", 32'(stall), 32'd0);
        tick();
        chk("lw_dest_ex", 32'(bus.dest_ex), 32'd5);
        chk("lw_mem_read_ex", 32'(bus.mem_read_ex), 32'd1);
        chk("lw_imm_ex", bus.imm_ex, 32'h4);
        id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 32'h0, 32'h22, 32'h0, C_RTYPE, 3'd2);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_if_id_write", 32'(if_id_write), 32'd0);
        tick();
        chk("lu_bub_valid", 32'(bus.valid_ex), 32'd0);
        chk("lu_bub_reg_write", 32'(bus.reg_write_ex), 32'd0);
        chk("lu_bub_mem_read", 32'(bus.mem_read_ex), 32'd0);
        chk("lu_bub_rs", 32'(bus.rs_ex), 32'd0);
        chk("lu_count1", 32'(stall_count), 32'd1);
        chk("lu_release", 32'(pc_write), 32'd1);
        tick();
        chk("lu_adv_rs", 32'(bus.rs_ex), 32'd5);
        chk("lu_adv_dest", 32'(bus.dest_ex), 32'd6);
        chk("lu_adv_count", 32'(stall_count), 32'd1);

        // lw $5 then addi $7,$5,8: rs match stalls
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 32'h0, 32'h0, 32'h8, C_ADDI, 3'd0);
        chk("addi_stall", 32'(stall), 32'd1);
        tick();
        chk("addi_count2", 32'(stall_count), 32'd2);
        tick();
        chk("addi_dest", 32'(bus.dest_ex), 32'd7);

        // lw $5 then lui $5 (rs=0, rt unused): no stall
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 32'h1234, C_ADDI, 3'd5);
        chk("lui_stall", 32'(stall), 32'd0);
        tick();
        chk("lui_valid", 32'(bus.valid_ex), 32'd1);
        chk("lui_dest", 32'(bus.dest_ex), 32'd5);

        // hazard with flush: bubble, no stall, no count
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 32'h0, 32'h22, 32'h0, C_RTYPE, 3'd2);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_pc_write", 32'(pc_write), 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(bus.valid_ex), 32'd0);
        chk("fl_count", 32'(stall_count), 32'd2);

        // dependent but not valid in ID: no stall, bubble
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b0, 5'd5, 5'd2, 5'd6, 1'b1, 32'h0, 32'h22, 32'h0, C_RTYPE, 3'd2);
        chk("inv_stall", 32'(stall), 32'd0);
        tick();
        chk("inv_valid", 32'(bus.valid_ex), 32'd0);

        // lw $0 then reader of $0: no stall
        id(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0, C_RTYPE, 3'd2);
        chk("z_stall", 32'(stall), 32'd0);
        tick();

        // lw $5 then add $6,$1,$5: Rt match stalls when Rt is used
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 32'h11, 32'h0, 32'h0, C_RTYPE, 3'd2);
        chk("rt_stall", 32'(stall), 32'd1);
        tick();
        chk("rt_count3", 32'(stall_count), 32'd3);
        tick();
        chk("rt_adv_rt", 32'(bus.rt_ex), 32'd5);

        // add $0,$1,$2: write suppressed
        id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 32'h11, 32'h22, 32'h0, C_RTYPE, 3'd2);
        tick();
        chk("r0_dest", 32'(bus.dest_ex), 32'd0);
        chk("r0_reg_write", 32'(bus.reg_write_ex), 32'd0);
        chk("r0_valid", 32'(bus.valid_ex), 32'd1);

        // one more stall: counter saturates at 3
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 32'h0, 32'h22, 32'h0, C_RTYPE, 3'd2);
        chk("sat_stall", 32'(stall), 32'd1);
        tick();
        chk("sat_count", 32'(stall_count), 32'd3);
        tick();

        // reset mid-stall
        id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW, 3'd0);
        tick();
        id(1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 32'h0, 32'h22, 32'h0, C_RTYPE, 3'd2);
        chk("mr_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.valid_ex), 32'd0);
        chk("mr_rdata1", bus.rdata1_ex, 32'h0);
        chk("mr_mem_read", 32'(bus.mem_read_ex), 32'd0);
        chk("mr_count", 32'(stall_count), 32'd0);
        chk("mr_stall_clr", 32'(stall), 32'd0);
        chk("mr_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("mr_hold_dest", 32'(bus.dest_ex), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
